modbus_rtu_tx_framer: RTL and testbench
=======================================

# modbus_rtu_tx_framer

Response-path stage between the Modbus controller and `uart_bridge` in `top_modbus_converter`. It accepts a response ADU byte stream (address byte plus PDU) from the controller and forwards it to the bridge transmitter. It appends the Modbus CRC-16, low byte first, and enforces the RTU inter-frame silence before each frame starts. Frame-length overflow is reported through `len_err_o`.

## Interface
Parameters:
- `SIL_W`, default 24: width of the silence counter and of `silence_cycles_i`.
- `MAX_LEN`, default 254: maximum number of input bytes (address + PDU) per frame.

Ports:
- `PCLK`  in  1  clock.
- `PRESETn`  in  1  reset, asynchronous, active-low.
- `silence_cycles_i`  in  SIL_W  required idle-line cycles before a frame; CSR computes this as 3.5 chars.
- `tx_idle_i`  in  1  bridge TX shifter idle and line at stop level (`stat_tx_empty`).
- `in_data_i`  in  8  ADU byte from controller.
- `in_valid_i`  in  1  byte valid.
- `in_last_i`  in  1  final ADU byte; qualified by `in_valid_i`.
- `in_ready_o`  out  1  byte accepted when `in_valid_i && in_ready_o`.
- `tx_data_o`  out  8  byte to bridge.
- `tx_valid_o`  out  1  registered valid to bridge.
- `tx_ready_i`  in  1  bridge accepts when `tx_valid_o && tx_ready_i`.
- `busy_o`  out  1  frame in progress (state ≠ GAP).
- `frame_done_o`  out  1  1-cycle pulse when the CRC high byte is accepted.
- `len_err_o`  out  1  1-cycle pulse on overflow termination.

## Operation
- States are GAP, DATA, DRAIN, CRC_LO, CRC_HI and DONE.
- **GAP**
  - `sil_cnt` increments, saturating, while `tx_idle_i && !tx_valid_o`; any other cycle clears it to 0.
  - Transition to DATA when `sil_cnt >= silence_cycles_i && in_valid_i`.
  - `silence_cycles_i = 0` means no gap is required.
- **DATA**
  - `in_ready_o = !tx_valid_o || tx_ready_i` (combinational). In every other state `in_ready_o` is 0.
  - On accept: the output register loads the byte, `crc` updates, and `len` increments.
  - If the accepted byte has `in_last_i` set, go to CRC_LO.
  - If `len` reaches MAX_LEN without `in_last_i`, go to DRAIN.
- **DRAIN**
  - `in_ready_o = 1`; bytes are accepted and discarded, with no CRC or length update.
  - On `in_last_i`, pulse `len_err_o` and go to CRC_LO.
- **CRC_LO**: when the output register is free, load `crc[7:0]` and go to CRC_HI.
- **CRC_HI**: when the output register is free, load `crc[15:8]` and go to DONE.
- **DONE**: when the high byte handshake completes, pulse `frame_done_o`, clear `sil_cnt`, and go to GAP.
- CRC arithmetic:
  - Initial value 16'hFFFF, reflected polynomial 16'hA001.
  - Per byte: `crc ^= byte`, then 8 iterations of shift-right with conditional XOR.
  - Computed byte-parallel in one cycle.
  - `crc` and `len` are re-initialised on GAP→DATA.
- The output register holds `tx_data_o` stable while `tx_valid_o && !tx_ready_i`; no byte is ever dropped or duplicated.

## Timing
- Reset values:
  - `tx_valid_o=0`, `tx_data_o=8'h00`, `in_ready_o=0`, `busy_o=0`, `frame_done_o=0`, `len_err_o=0`.
  - State GAP, `sil_cnt=0`, `crc=16'hFFFF`, `len=0`.
- Input byte accepted at cycle N appears on `tx_data_o`/`tx_valid_o` at N+1.
- Full throughput: with `tx_ready_i` held at 1, one byte per cycle. The CRC bytes follow the last data byte in consecutive cycles.
- GAP→DATA takes 1 cycle; the first byte can be accepted in the cycle after the transition.
- After `frame_done_o`, `sil_cnt` must be rebuilt from 0, so the next frame cannot start before `silence_cycles_i` idle cycles have elapsed.
- A reset assertion mid-frame returns all state immediately to reset values. Any partial frame is abandoned, and the next frame requires a full silence period.
- Simultaneous `in_last_i` with the MAX_LEN-th byte is a normal termination: no DRAIN and no `len_err_o`.

## Structure
- Shared package `modbus_pkg` holds:
  - `CRC16_INIT` (16'hFFFF) and `CRC16_POLY` (16'hA001);
  - `MODBUS_MAX_ADU` (256);
  - the framer state enum;
  - function `crc16_byte(crc, byte)`.
- One combinational sub-module, `modbus_crc16_byte`, wraps the function so the RX checker can reuse it.
- The state machine, output register, silence counter and length counter stay in the top module.

## Test plan
1. Send 01 05 00 00 FF 00 (last on FF 00's final byte 00) with `tx_ready_i=1` and `silence_cycles_i=0` → `tx_data_o` sequence is 01 05 00 00 FF 00 8C 3A, with one `frame_done_o` pulse.
2. Send 01 01 01 01 with `tx_ready_i` high one cycle in three → output 01 01 01 01 90 48, each byte held stable until handshake, no duplicates.
3. Send single byte 01 marked last → output 01 7E 80. Then send 01 02 01 01 → output 01 02 01 01 60 48, with `crc` correctly re-initialised between frames.
4. `silence_cycles_i=100`, `tx_idle_i=1`, back-to-back frames → first `tx_valid_o` of frame 2 is ≥101 cycles after `frame_done_o`. Dropping `tx_idle_i` for 1 cycle at gap cycle 50 delays it by a further ≥51 cycles.
5. Send 256 bytes with last on the 256th → 254 bytes forwarded, then their CRC; `len_err_o` pulses once; all 256 inputs are accepted.
6. Assert `PRESETn` during DATA after 3 bytes → all outputs go to reset values within the same cycle. A new frame then starts only after a full `silence_cycles_i` and yields the correct CRC.

Source files
------------

// File: rtl/modbus_pkg.sv
// Shared Modbus definitions: CRC-16 constants, ADU limit, framer states and
// the byte-wise CRC update used by both the TX framer and the RX checker.
package modbus_pkg;

  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY     = 16'hA001;
  localparam int          MODBUS_MAX_ADU = 256;

  typedef enum logic [2:0] {
    ST_GAP,
    ST_DATA,
    ST_DRAIN,
    ST_CRC_LO,
    ST_CRC_HI,
    ST_DONE
  } framer_state_e;

  // Reflected CRC-16: fold the byte into the low end, then eight LSB-first shifts.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/modbus_crc16_byte.sv
// Single-cycle Modbus CRC-16 update for one byte; shared by the TX framer
// and the RX checker.
module modbus_crc16_byte
  import modbus_pkg::*;
(
  input  logic [15:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [15:0] o_crc
);

  assign o_crc = crc16_byte(i_crc, i_data);

endmodule

// File: rtl/modbus_rtu_tx_framer.sv
// Modbus RTU response framer: waits for line silence, forwards the ADU bytes,
// appends the CRC-16 low byte first and flags frames that exceed MAX_LEN.
module modbus_rtu_tx_framer
  import modbus_pkg::*;
#(
  parameter int SIL_W   = 24,
  parameter int MAX_LEN = 254
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic [SIL_W-1:0] silence_cycles_i,
  input  logic             tx_idle_i,
  input  logic [7:0]       in_data_i,
  input  logic             in_valid_i,
  input  logic             in_last_i,
  output logic             in_ready_o,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             len_err_o
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  framer_state_e    r_state;
  framer_state_e    w_state_nxt;
  logic [SIL_W-1:0] r_sil_cnt;
  logic [15:0]      r_crc;
  logic [15:0]      w_crc_upd;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_len_inc;
  logic [7:0]       r_tx_data;
  logic             r_tx_valid;
  logic             w_out_free;
  logic             w_load;
  logic [7:0]       w_load_data;
  logic             w_data_acc;
  logic             w_gap_met;
  logic             w_line_quiet;

  modbus_crc16_byte u_crc16 (
    .i_crc  (r_crc),
    .i_data (in_data_i),
    .o_crc  (w_crc_upd)
  );

  assign w_out_free   = !r_tx_valid || tx_ready_i;
  assign w_data_acc   = (r_state == ST_DATA) && in_valid_i && w_out_free;
  assign w_len_inc    = r_len + 1'b1;
  assign w_gap_met    = r_sil_cnt >= silence_cycles_i;
  assign w_line_quiet = tx_idle_i && !r_tx_valid;

  assign tx_data_o  = r_tx_data;
  assign tx_valid_o = r_tx_valid;
  assign busy_o     = (r_state != ST_GAP);

  always_comb begin
    w_state_nxt  = r_state;
    in_ready_o   = 1'b0;
    w_load       = 1'b0;
    w_load_data  = in_data_i;
    len_err_o    = 1'b0;
    frame_done_o = 1'b0;
    case (r_state)
      ST_GAP: begin
        if (w_gap_met && in_valid_i) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        in_ready_o = w_out_free;
        if (w_data_acc) begin
          w_load = 1'b1;
          // A last flag on the MAX_LEN-th byte is a normal end, so it wins.
          if (in_last_i)                         w_state_nxt = ST_CRC_LO;
          else if (w_len_inc == LEN_W'(MAX_LEN)) w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        in_ready_o = 1'b1;
        if (in_valid_i && in_last_i) begin
          len_err_o   = 1'b1;
          w_state_nxt = ST_CRC_LO;
        end
      end
      ST_CRC_LO: begin
        if (w_out_free) begin
          w_load      = 1'b1;
          w_load_data = r_crc[7:0];
          w_state_nxt = ST_CRC_HI;
        end
      end
      ST_CRC_HI: begin
        if (w_out_free) begin
          w_load      = 1'b1;
          w_load_data = r_crc[15:8];
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (r_tx_valid && tx_ready_i) begin
          frame_done_o = 1'b1;
          w_state_nxt  = ST_GAP;
        end
      end
      default: w_state_nxt = ST_GAP;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= ST_GAP;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
    end else if (w_load) begin
      r_tx_data  <= w_load_data;
      r_tx_valid <= 1'b1;
    end else if (tx_ready_i) begin
      r_tx_valid <= 1'b0;
    end
  end

  // Silence only accumulates between frames, so leaving GAP always restarts it.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_sil_cnt <= '0;
    end else if (r_state == ST_GAP && w_line_quiet) begin
      if (r_sil_cnt != '1) r_sil_cnt <= r_sil_cnt + 1'b1;
    end else begin
      r_sil_cnt <= '0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_crc <= CRC16_INIT;
      r_len <= '0;
    end else if (r_state == ST_GAP && w_state_nxt == ST_DATA) begin
      r_crc <= CRC16_INIT;
      r_len <= '0;
    end else if (w_data_acc) begin
      r_crc <= w_crc_upd;
      r_len <= w_len_inc;
    end
  end

endmodule

// File: tb/tb_modbus_rtu_tx_framer.sv
// Self-checking bench for modbus_rtu_tx_framer: directed and randomized frames
// compared against a bit-serial CRC model and frame-level expectations.
module tb_modbus_rtu_tx_framer;

  localparam int SIL_W   = 24;
  localparam int MAX_LEN = 254;

  logic             PCLK;
  logic             PRESETn;
  logic [SIL_W-1:0] silence_cycles_i;
  logic             tx_idle_i;
  logic [7:0]       in_data_i;
  logic             in_valid_i;
  logic             in_last_i;
  logic             in_ready_o;
  logic [7:0]       tx_data_o;
  logic             tx_valid_o;
  logic             tx_ready_i;
  logic             busy_o;
  logic             frame_done_o;
  logic             len_err_o;

  modbus_rtu_tx_framer #(.SIL_W(SIL_W), .MAX_LEN(MAX_LEN)) dut (
    .PCLK             (PCLK),
    .PRESETn          (PRESETn),
    .silence_cycles_i (silence_cycles_i),
    .tx_idle_i        (tx_idle_i),
    .in_data_i        (in_data_i),
    .in_valid_i       (in_valid_i),
    .in_last_i        (in_last_i),
    .in_ready_o       (in_ready_o),
    .tx_data_o        (tx_data_o),
    .tx_valid_o       (tx_valid_o),
    .tx_ready_i       (tx_ready_i),
    .busy_o           (busy_o),
    .frame_done_o     (frame_done_o),
    .len_err_o        (len_err_o)
  );

  int errors = 0;
  int checks = 0;
  int timeouts = 0;

  int cyc = 0;
  int readyMode = 0;
  int dropCyc = -1;

  logic [7:0] stimQ[$];
  logic [7:0] gotQ[$];
  int         gotCyc[$];
  int acceptCnt = 0, doneCnt = 0, lenErrCnt = 0, holdViol = 0;
  int doneCyc = -1, firstRise = -1, firstAcc = -1;
  int accBase, doneBase, lenErrBase;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Bridge model: counts cycles and drives ready/idle just after each rising edge.
  initial begin
    tx_ready_i = 1'b0;
    tx_idle_i  = 1'b1;
    forever begin
      @(posedge PCLK);
      cyc++;
      #1;
      case (readyMode)
        0:       tx_ready_i = 1'b1;
        1:       tx_ready_i = (cyc % 3 == 0);
        default: tx_ready_i = 1'($urandom_range(0, 1));
      endcase
      tx_idle_i = (cyc != dropCyc);
    end
  end

  // Monitor: records handshakes, pulses and hold-stability violations on the falling edge.
  initial begin
    logic       pend;
    logic [7:0] pendData;
    logic       prevValid;
    pend = 1'b0;
    pendData = 8'h00;
    prevValid = 1'b0;
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        pend = 1'b0;
        prevValid = 1'b0;
      end else begin
        if (pend && !(tx_valid_o === 1'b1 && tx_data_o === pendData)) holdViol++;
        pend = tx_valid_o && !tx_ready_i;
        pendData = tx_data_o;
        if (tx_valid_o && tx_ready_i) begin
          gotQ.push_back(tx_data_o);
          gotCyc.push_back(cyc);
        end
        if (in_valid_i && in_ready_o) begin
          acceptCnt++;
          if (firstAcc < 0) firstAcc = cyc;
        end
        if (tx_valid_o && !prevValid && firstRise < 0) firstRise = cyc;
        prevValid = tx_valid_o;
        if (frame_done_o) begin
          doneCnt++;
          doneCyc = cyc;
        end
        if (len_err_o) lenErrCnt++;
      end
    end
  end

  // Reference CRC: bit-serial LFSR over the first n stimulus bytes, LSB first.
  function automatic logic [15:0] refCrc(input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ stimQ[i][b];
        c  = {1'b0, c[15:1]};
        if (fb) c = c ^ 16'hA001;
      end
    end
    return c;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // Offers every byte of stimQ with a bounded wait for acceptance.
  task automatic applyStimulus(input bit useGaps, input bit markLast);
    int budget;
    int g;
    for (int i = 0; i < stimQ.size(); i++) begin
      if (useGaps) begin
        g = $urandom_range(0, 2);
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        repeat (g) stepCycles(1);
      end
      in_data_i  = stimQ[i];
      in_valid_i = 1'b1;
      in_last_i  = markLast && (i == stimQ.size() - 1);
      budget = 0;
      forever begin
        @(negedge PCLK);
        if (in_ready_o) break;
        budget++;
        if (budget > 1000) begin
          timeouts++;
          break;
        end
      end
      stepCycles(1);
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic waitFrameDone();
    int budget;
    budget = 0;
    forever begin
      @(posedge PCLK);
      if (doneCnt > doneBase) break;
      budget++;
      if (budget > 3000) begin
        timeouts++;
        break;
      end
    end
    #1;
  endtask

  task automatic beginFrame();
    gotQ.delete();
    gotCyc.delete();
    accBase    = acceptCnt;
    doneBase   = doneCnt;
    lenErrBase = lenErrCnt;
    firstRise  = -1;
    firstAcc   = -1;
  endtask

  task automatic fillRandom(input int n);
    stimQ.delete();
    for (int i = 0; i < n; i++) stimQ.push_back(8'($urandom));
  endtask

  // Frame-level expectations: bytes up to MAX_LEN, then their CRC low/high.
  task automatic checkFrame(input string tag);
    logic [7:0]  expQ[$];
    logic [15:0] c;
    logic [7:0]  obs;
    int          n, fwd;
    n   = stimQ.size();
    fwd = (n > MAX_LEN) ? MAX_LEN : n;
    for (int i = 0; i < fwd; i++) expQ.push_back(stimQ[i]);
    c = refCrc(fwd);
    expQ.push_back(c[7:0]);
    expQ.push_back(c[15:8]);
    checkOutput($sformatf("%s_count", tag), gotQ.size(), expQ.size());
    for (int i = 0; i < expQ.size(); i++) begin
      obs = (i < gotQ.size()) ? gotQ[i] : 8'hxx;
      checkOutput($sformatf("%s_b%0d", tag, i), obs, expQ[i]);
    end
    checkOutput($sformatf("%s_done", tag), doneCnt - doneBase, 1);
    checkOutput($sformatf("%s_lenerr", tag), lenErrCnt - lenErrBase, (n > MAX_LEN) ? 1 : 0);
    checkOutput($sformatf("%s_accepts", tag), acceptCnt - accBase, n);
    checkOutput($sformatf("%s_hold", tag), holdViol, 0);
    checkOutput($sformatf("%s_idle", tag), busy_o, 1'b0);
    checkOutput($sformatf("%s_timeouts", tag), timeouts, 0);
  endtask

  initial begin
    int relCyc;
    int d;
    int n;
    bit gaps;

    // Reset: every output must sit at its reset value.
    PRESETn = 1'b0;
    silence_cycles_i = '0;
    in_data_i  = 8'h00;
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    stepCycles(3);
    checkOutput("rst_tx_valid", tx_valid_o, 1'b0);
    checkOutput("rst_tx_data", tx_data_o, 8'h00);
    checkOutput("rst_in_ready", in_ready_o, 1'b0);
    checkOutput("rst_busy", busy_o, 1'b0);
    checkOutput("rst_done", frame_done_o, 1'b0);
    checkOutput("rst_lenerr", len_err_o, 1'b0);
    PRESETn = 1'b1;
    stepCycles(2);

    // Known Modbus write-coil request at full throughput.
    readyMode = 0;
    stimQ = '{8'h01, 8'h05, 8'h00, 8'h00, 8'hFF, 8'h00};
    beginFrame();
    applyStimulus(1'b0, 1'b1);
    waitFrameDone();
    stepCycles(3);
    checkFrame("t1");
    checkOutput("t1_crc_lo", (gotQ.size() > 6) ? gotQ[6] : 8'hxx, 8'h8C);
    checkOutput("t1_crc_hi", (gotQ.size() > 7) ? gotQ[7] : 8'hxx, 8'h3A);
    checkOutput("t1_latency", firstRise - firstAcc, 1);
    checkOutput("t1_span", (gotCyc.size() == 8) ? gotCyc[7] - gotCyc[0] : -1, 7);

    // Back-pressured bridge: ready one cycle in three.
    readyMode = 1;
    stimQ = '{8'h01, 8'h01, 8'h01, 8'h01};
    beginFrame();
    applyStimulus(1'b1, 1'b1);
    waitFrameDone();
    stepCycles(3);
    checkFrame("t2");

    // Single-byte frame followed by a second frame: CRC restarts per frame.
    readyMode = 2;
    stimQ = '{8'h01};
    beginFrame();
    applyStimulus(1'b0, 1'b1);
    waitFrameDone();
    stepCycles(2);
    checkFrame("t3a");
    stimQ = '{8'h01, 8'h02, 8'h01, 8'h01};
    beginFrame();
    applyStimulus(1'b1, 1'b1);
    waitFrameDone();
    stepCycles(2);
    checkFrame("t3b");

    // Randomized frames with random bridge back-pressure and input gaps.
    for (int f = 0; f < 4; f++) begin
      readyMode = $urandom_range(0, 2);
      n = $urandom_range(1, 12);
      gaps = 1'($urandom_range(0, 1));
      fillRandom(n);
      beginFrame();
      applyStimulus(gaps, 1'b1);
      waitFrameDone();
      stepCycles(2);
      checkFrame($sformatf("rnd%0d", f));
    end

    // Length boundaries: last on the MAX_LEN-th byte, then an overlong frame.
    readyMode = 2;
    fillRandom(MAX_LEN);
    beginFrame();
    applyStimulus(1'b0, 1'b1);
    waitFrameDone();
    stepCycles(2);
    checkFrame("t5_exact");
    fillRandom(256);
    beginFrame();
    applyStimulus(1'b0, 1'b1);
    waitFrameDone();
    stepCycles(2);
    checkFrame("t5_over");

    // Inter-frame silence of 100 cycles, measured from frame_done.
    readyMode = 0;
    silence_cycles_i = SIL_W'(100);
    fillRandom(4);
    beginFrame();
    applyStimulus(1'b0, 1'b1);
    waitFrameDone();
    d = doneCyc;
    fillRandom(5);
    beginFrame();
    applyStimulus(1'b0, 1'b1);
    checkOutput("t4_gap", firstRise - d, 100 + 3);
    waitFrameDone();
    d = doneCyc;
    stepCycles(3);
    checkFrame("t4b");
    dropCyc = d + 51;
    fillRandom(3);
    beginFrame();
    applyStimulus(1'b0, 1'b1);
    checkOutput("t4_gap_drop", firstRise - d, 51 + 100 + 3);
    waitFrameDone();
    stepCycles(3);
    checkFrame("t4c");
    dropCyc = -1;

    // Reset mid-frame after three bytes, then a clean frame after full silence.
    readyMode = 2;
    silence_cycles_i = SIL_W'(30);
    fillRandom(3);
    beginFrame();
    applyStimulus(1'b0, 1'b0);
    checkOutput("t6_busy_before", busy_o, 1'b1);
    in_valid_i = 1'b1;
    in_data_i  = 8'hA5;
    PRESETn = 1'b0;
    #1;
    checkOutput("t6_tx_valid", tx_valid_o, 1'b0);
    checkOutput("t6_tx_data", tx_data_o, 8'h00);
    checkOutput("t6_in_ready", in_ready_o, 1'b0);
    checkOutput("t6_busy", busy_o, 1'b0);
    checkOutput("t6_done", frame_done_o, 1'b0);
    checkOutput("t6_lenerr", len_err_o, 1'b0);
    in_valid_i = 1'b0;
    stepCycles(2);
    PRESETn = 1'b1;
    relCyc = cyc;
    fillRandom(5);
    beginFrame();
    applyStimulus(1'b0, 1'b1);
    checkOutput("t6_gap", firstRise - relCyc, 30 + 2);
    waitFrameDone();
    stepCycles(2);
    checkFrame("t6");

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
